// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared fetch-path widths, memory depth and NOP encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam int          C_ADDR_W     = 10;
    localparam int          C_INSTR_W    = 32;
    localparam int          C_DEPTH      = 1 << C_ADDR_W;
    localparam logic [31:0] C_NOP_INSTR  = 32'h0000_0013;
    localparam int          C_FIFO_DEPTH = 2;

    typedef logic [1:0] fifo_count_t;

    // Slots committed after this edge: buffered plus in-flight, minus a pop.
    function automatic logic [2:0] fifo_occupancy(
        input fifo_count_t count,
        input logic        inflight,
        input logic        pop
    );
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Fetch request, decode handoff and program-load bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int INSTR_W = C_INSTR_W
);
    logic [ADDR_W-1:0]  instruction_address;
    logic               pc_valid;
    logic               pc_ready;
    logic               flush;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_waddr;
    logic [INSTR_W-1:0] imem_wdata;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output instruction_address, pc_valid, flush,
        output imem_we, imem_waddr, imem_wdata, instr_ready,
        input  pc_ready, instruction, instr_pc, instr_valid
    );

    modport slave (
        input  instruction_address, pc_valid, flush,
        input  imem_we, imem_waddr, imem_wdata, instr_ready,
        output pc_ready, instruction, instr_pc, instr_valid
    );
endinterface
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : Single-write-port instruction RAM with registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int INSTR_W = C_INSTR_W,
    parameter int DEPTH   = C_DEPTH
) (
    input  wire logic               clk,
    input  wire logic               we,
    input  wire logic [ADDR_W-1:0]  waddr,
    input  wire logic [INSTR_W-1:0] wdata,
    input  wire logic               re,
    input  wire logic [ADDR_W-1:0]  raddr,
    output logic      [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    // Non-blocking update gives read-old-data on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Credit-controlled fetch with one-cycle RAM and 2-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int INSTR_W = C_INSTR_W,
    parameter int DEPTH   = C_DEPTH
) (
    input  wire logic         clk,
    input  wire logic         reset,
    instruction_fetch_if.slave bus
);

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_accept;
    logic               w_pc_ready;
    logic [2:0]         w_occ;
    logic [INSTR_W-1:0] w_rdata;

    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [INSTR_W-1:0] r_word [C_FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_pc   [C_FIFO_DEPTH];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    fifo_count_t        r_count;

    always_comb begin
        w_valid    = (r_count != 2'd0);
        w_pop      = w_valid && bus.instr_ready;
        w_occ      = fifo_occupancy(r_count, r_inflight, w_pop);
        w_pc_ready = (w_occ < 3'd2) && !bus.flush;
        w_accept   = bus.pc_valid && w_pc_ready;
        w_push     = r_inflight && !bus.flush;
    end

    assign bus.pc_ready    = w_pc_ready;
    assign bus.instr_valid = w_valid;
    assign bus.instruction = w_valid ? r_word[r_rd_ptr] : '0;
    assign bus.instr_pc    = w_valid ? r_pc[r_rd_ptr]   : '0;

    instruction_memory #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_imem (
        .clk   (clk),
        .we    (bus.imem_we),
        .waddr (bus.imem_waddr),
        .wdata (bus.imem_wdata),
        .re    (w_accept),
        .raddr (bus.instruction_address),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count       <= 2'd0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                r_word[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (bus.flush) begin
            // The read already launched is simply never pushed.
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_inflight_pc <= bus.instruction_address;
            end
            if (w_push) begin
                r_word[r_wr_ptr] <= w_rdata;
                r_pc[r_wr_ptr]   <= r_inflight_pc;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    typedef struct packed {
        logic [31:0] word;
        logic [9:0]  pc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pops    = 0;
    int   stalls  = 0;
    int   m_inflight = 0;
    logic [31:0] last_word = '0;
    logic [9:0]  last_pc   = '0;
    logic [31:0] mm [1024];
    exp_t q [$];

    instruction_fetch_if #(.ADDR_W(10), .INSTR_W(32)) bus ();

    instruction_fetch #(
        .ADDR_W  (10),
        .INSTR_W (32),
        .DEPTH   (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: queue holds buffered words followed by the in-flight one.
    always @(negedge clk) begin
        int   m_count;
        int   pop;
        logic exp_ready;
        if (!reset) begin
            q.delete();
            m_inflight = 0;
        end else begin
            m_count   = q.size() - m_inflight;
            pop       = ((m_count != 0) && bus.instr_ready) ? 1 : 0;
            exp_ready = ((m_count + m_inflight - pop) < 2) && !bus.flush;
            chk("instr_valid", {63'd0, bus.instr_valid}, {63'd0, m_count != 0});
            chk("pc_ready", {63'd0, bus.pc_ready}, {63'd0, exp_ready});
            if (m_count != 0) begin
                chk("instruction", {32'd0, bus.instruction}, {32'd0, q[0].word});
                chk("instr_pc", {54'd0, bus.instr_pc}, {54'd0, q[0].pc});
            end
            if (bus.flush) begin
                q.delete();
                m_inflight = 0;
            end else begin
                if (pop != 0) begin
                    last_word = q[0].word;
                    last_pc   = q[0].pc;
                    void'(q.pop_front());
                    pops++;
                end
                if (bus.pc_valid && exp_ready) begin
                    q.push_back('{word: mm[bus.instruction_address], pc: bus.instruction_address});
                    m_inflight = 1;
                end else begin
                    m_inflight = 0;
                end
            end
        end
        if (bus.imem_we) mm[bus.imem_waddr] = bus.imem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = a;
        bus.imem_wdata = d;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    task automatic issue(input logic [9:0] a);
        bit ok;
        ok = 1'b0;
        bus.pc_valid            = 1'b1;
        bus.instruction_address = a;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.pc_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) chk("issue_timeout", 64'd1, 64'd0);
        tick();
        bus.pc_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset                   = 1'b0;
        bus.pc_valid            = 1'b0;
        bus.instruction_address = '0;
        bus.flush               = 1'b0;
        bus.imem_we             = 1'b0;
        bus.imem_waddr          = '0;
        bus.imem_wdata          = '0;
        bus.instr_ready         = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, bus.instruction}, 64'd0);
        chk("rst_pc", {54'd0, bus.instr_pc}, 64'd0);
        reset = 1'b1;

        wr(10'd0, 32'h11);
        wr(10'd1, 32'h22);
        wr(10'd2, 32'h33);
        wr(10'd3, 32'h44);
        wr(10'd5, 32'hAA);
        wr(10'd1023, 32'hDEAD);

        // Back-to-back stream at full rate
        bus.instr_ready = 1'b1;
        stalls = 0;
        p0 = pops;
        for (int i = 0; i < 4; i++) issue(10'(i));
        chk("t1_stalls", 64'(stalls), 64'd0);
        drain();
        chk("t1_pops", 64'(pops - p0), 64'd4);
        chk("t1_last", {32'd0, last_word}, 64'h44);

        // Stalled decode: two accepts then back-pressure
        bus.instr_ready = 1'b0;
        p0 = pops;
        issue(10'd0);
        issue(10'd1);
        bus.pc_valid            = 1'b1;
        bus.instruction_address = 10'd2;
        repeat (4) tick();
        chk("t2_ready", {63'd0, bus.pc_ready}, 64'd0);
        chk("t2_hold", {32'd0, bus.instruction}, 64'h11);
        bus.instr_ready = 1'b1;
        issue(10'd2);
        issue(10'd3);
        drain();
        chk("t2_pops", 64'(pops - p0), 64'd4);

        // Flush kills the in-flight fetch of address 2
        p0 = pops;
        issue(10'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        issue(10'd3);
        drain();
        chk("t3_pops", 64'(pops - p0), 64'd1);
        chk("t3_word", {32'd0, last_word}, 64'h44);
        chk("t3_pc", {54'd0, last_pc}, 64'd3);

        // Same-edge write and read of one address returns the old word
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 10'd5;
        bus.imem_wdata = 32'hBB;
        issue(10'd5);
        bus.imem_we    = 1'b0;
        drain();
        chk("t4_old", {32'd0, last_word}, 64'hAA);
        issue(10'd5);
        drain();
        chk("t4_new", {32'd0, last_word}, 64'hBB);

        // Top of the address space
        issue(10'd1023);
        drain();
        chk("t5_word", {32'd0, last_word}, 64'hDEAD);
        chk("t5_pc", {54'd0, last_pc}, 64'd1023);

        // Asynchronous reset with two buffered words
        bus.instr_ready = 1'b0;
        issue(10'd0);
        issue(10'd1);
        tick();
        chk("t6_full", {63'd0, bus.pc_ready}, 64'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("t6_instr", {32'd0, bus.instruction}, 64'd0);
        chk("t6_pc", {54'd0, bus.instr_pc}, 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_ready", {63'd0, bus.pc_ready}, 64'd1);
        bus.instr_ready = 1'b1;
        issue(10'd0);
        drain();
        chk("t6_mem", {32'd0, last_word}, 64'h11);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
